// File: rtl/gray_to_binary_tracker.sv
// Gray-to-binary decoder with step tracking and a valid/ready output stage.
// Define GRAY_ERRCNT_EN to build the saturating step-error counter.
module gray_to_binary_tracker #(
   parameter int WIDTH = 4
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [WIDTH-1:0] in_gray,
   input  logic             in_valid,
   output logic             in_ready,
   output logic [WIDTH-1:0] out_bin,
   output logic             out_valid,
   input  logic             out_ready,
   output logic             step_up,
   output logic             step_down,
   output logic             step_err,
   output logic             err_sticky,
   input  logic             err_clr,
   output logic [7:0]       err_cnt
);

   typedef enum logic {
      S_INIT,
      S_TRACK
   } state_t;

   state_t           r_state;
   logic [WIDTH-1:0] r_prev;
   logic [WIDTH-1:0] r_bin;
   logic             r_valid;
   logic             r_up;
   logic             r_down;
   logic             r_err;
   logic             r_sticky;

   logic [WIDTH-1:0] w_bin;
   logic [WIDTH-1:0] w_delta;
   logic             w_acc;
   logic             w_up;
   logic             w_down;
   logic             w_bad;
   logic             w_err_ev;

   // Each binary bit is the XOR of all Gray bits at or above it.
   always_comb begin
      w_bin = '0;
      for (int i = 0; i < WIDTH; i++) begin
         w_bin[i] = ^(in_gray >> i);
      end
   end

   assign in_ready = !r_valid || out_ready;
   assign w_acc    = in_valid && in_ready;
   assign w_delta  = w_bin - r_prev;
   assign w_up     = (w_delta == WIDTH'(1));
   assign w_down   = (w_delta == {WIDTH{1'b1}});
   assign w_bad    = (w_delta != '0) && !w_up && !w_down;
   assign w_err_ev = w_acc && (r_state == S_TRACK) && w_bad;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state <= S_INIT;
         r_prev  <= '0;
         r_bin   <= '0;
         r_valid <= 1'b0;
         r_up    <= 1'b0;
         r_down  <= 1'b0;
         r_err   <= 1'b0;
      end else if (w_acc) begin
         r_valid <= 1'b1;
         r_bin   <= w_bin;
         r_prev  <= w_bin;
         unique case (r_state)
            S_INIT: begin
               r_up    <= 1'b0;
               r_down  <= 1'b0;
               r_err   <= 1'b0;
               r_state <= S_TRACK;
            end
            S_TRACK: begin
               r_up   <= w_up;
               r_down <= w_down;
               r_err  <= w_bad;
            end
            default: r_state <= S_INIT;
         endcase
      end else if (out_ready) begin
         r_valid <= 1'b0;
      end
   end

   // A fresh error outranks a simultaneous clear.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_sticky <= 1'b0;
      end else if (w_err_ev) begin
         r_sticky <= 1'b1;
      end else if (err_clr) begin
         r_sticky <= 1'b0;
      end
   end

`ifdef GRAY_ERRCNT_EN
   logic [7:0] r_cnt;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_cnt <= '0;
      end else if (err_clr) begin
         r_cnt <= w_err_ev ? 8'd1 : 8'd0;
      end else if (w_err_ev && (r_cnt != 8'hFF)) begin
         r_cnt <= r_cnt + 8'd1;
      end
   end

   assign err_cnt = r_cnt;
`else
   assign err_cnt = '0;
`endif

   assign out_bin    = r_bin;
   assign out_valid  = r_valid;
   assign step_up    = r_up;
   assign step_down  = r_down;
   assign step_err   = r_err;
   assign err_sticky = r_sticky;

endmodule

// File: tb/tb_gray_to_binary_tracker.sv
// Directed bench for gray_to_binary_tracker (WIDTH=4).
// Expected err_cnt follows GRAY_ERRCNT_EN.
module tb_gray_to_binary_tracker;

   localparam int W = 4;
`ifdef GRAY_ERRCNT_EN
   localparam logic [7:0] CNT1 = 8'd1;
`else
   localparam logic [7:0] CNT1 = 8'd0;
`endif

   logic         clk = 1'b0;
   logic         rst;
   logic [W-1:0] in_gray;
   logic         in_valid;
   logic         in_ready;
   logic [W-1:0] out_bin;
   logic         out_valid;
   logic         out_ready;
   logic         step_up;
   logic         step_down;
   logic         step_err;
   logic         err_sticky;
   logic         err_clr;
   logic [7:0]   err_cnt;

   int n_cmp = 0;
   int n_bad = 0;

   gray_to_binary_tracker #(.WIDTH(W)) dut (
      .clk        (clk),
      .rst        (rst),
      .in_gray    (in_gray),
      .in_valid   (in_valid),
      .in_ready   (in_ready),
      .out_bin    (out_bin),
      .out_valid  (out_valid),
      .out_ready  (out_ready),
      .step_up    (step_up),
      .step_down  (step_down),
      .step_err   (step_err),
      .err_sticky (err_sticky),
      .err_clr    (err_clr),
      .err_cnt    (err_cnt)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [7:0] obs,
                        input logic [7:0] exp);
      n_cmp++;
      if (obs !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h want %0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Checks the whole output bundle: valid, bin, {up,down,err}.
   task automatic chk_out(input string tag, input logic v,
                          input logic [3:0] b, input logic [2:0] f);
      check({tag, ".valid"}, {7'd0, out_valid}, {7'd0, v});
      check({tag, ".bin"}, {4'd0, out_bin}, {4'd0, b});
      check({tag, ".flags"}, {5'd0, step_up, step_down, step_err},
            {5'd0, f});
   endtask

   task automatic do_reset();
      rst      = 1'b1;
      in_valid = 1'b0;
      err_clr  = 1'b0;
      out_ready = 1'b1;
      in_gray  = '0;
      tick();
      tick();
      rst = 1'b0;
   endtask

   task automatic send(input logic [3:0] g);
      in_gray  = g;
      in_valid = 1'b1;
      tick();
   endtask

   initial begin
      do_reset();
      rst = 1'b1;
      #1;
      chk_out("rst", 1'b0, 4'd0, 3'b000);
      check("rst.rdy", {7'd0, in_ready}, 8'd1);
      check("rst.sticky", {7'd0, err_sticky}, 8'd0);
      check("rst.cnt", err_cnt, 8'd0);
      rst = 1'b0;

      // first sample, then counting up
      send(4'b0000); chk_out("first", 1'b1, 4'd0, 3'b000);
      send(4'b0001); chk_out("up1", 1'b1, 4'd1, 3'b100);
      send(4'b0011); chk_out("up2", 1'b1, 4'd2, 3'b100);
      send(4'b0010); chk_out("up3", 1'b1, 4'd3, 3'b100);
      check("up.sticky", {7'd0, err_sticky}, 8'd0);

      // wrap both directions
      do_reset();
      send(4'b1000); chk_out("w15", 1'b1, 4'd15, 3'b000);
      send(4'b0000); chk_out("wrapup", 1'b1, 4'd0, 3'b100);
      send(4'b1000); chk_out("wrapdn", 1'b1, 4'd15, 3'b010);

      // step error, then clear
      do_reset();
      send(4'b0001); chk_out("e1", 1'b1, 4'd1, 3'b000);
      send(4'b0010); chk_out("err", 1'b1, 4'd3, 3'b001);
      check("err.sticky", {7'd0, err_sticky}, 8'd1);
      check("err.cnt", err_cnt, CNT1);
      in_valid = 1'b0;
      err_clr  = 1'b1;
      tick();
      check("clr.sticky", {7'd0, err_sticky}, 8'd0);
      check("clr.cnt", err_cnt, 8'd0);
      check("clr.valid", {7'd0, out_valid}, 8'd0);
      // clear and new error on the same edge: error wins (3 -> 0)
      send(4'b0000);
      chk_out("errclr", 1'b1, 4'd0, 3'b001);
      check("errclr.sticky", {7'd0, err_sticky}, 8'd1);
      check("errclr.cnt", err_cnt, CNT1);
      err_clr = 1'b0;

      // backpressure: hold 3 cycles, then load with no bubble
      do_reset();
      send(4'b0000);
      out_ready = 1'b0;
      in_gray   = 4'b0001;
      #1;
      for (int i = 0; i < 3; i++) begin
         check("stall.rdy", {7'd0, in_ready}, 8'd0);
         chk_out("stall", 1'b1, 4'd0, 3'b000);
         tick();
      end
      out_ready = 1'b1;
      #1;
      check("unstall.rdy", {7'd0, in_ready}, 8'd1);
      tick();
      chk_out("nobubble", 1'b1, 4'd1, 3'b100);
      in_valid = 1'b0;
      tick();
      check("drain.valid", {7'd0, out_valid}, 8'd0);

      // mid-stream reset
      send(4'b0011);
      chk_out("pre", 1'b1, 4'd2, 3'b100);
      in_valid = 1'b0;
      rst = 1'b1;
      #1;
      chk_out("midrst", 1'b0, 4'd0, 3'b000);
      check("midrst.rdy", {7'd0, in_ready}, 8'd1);
      tick();
      rst = 1'b0;
      send(4'b0110);
      chk_out("afterrst", 1'b1, 4'd4, 3'b000);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***",
               n_cmp, n_bad);
      $finish;
   end

endmodule

// File: doc/gray_to_binary_tracker.md
GRAY_TO_BINARY_TRACKER -- requirements
Module: gray_to_binary_tracker

Interface
REQ-001 SHALL have parameter WIDTH, default 4: width of the Gray input and the binary output.
REQ-002 SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-003 SHALL have port rst, input, 1 bit: asynchronous, active-high reset.
REQ-004 SHALL have port in_gray, input, WIDTH bits: Gray-coded sample.
REQ-005 SHALL have port in_valid, input, 1 bit: in_gray holds a sample.
REQ-006 SHALL have port in_ready, output, 1 bit: block can accept a sample this cycle.
REQ-007 SHALL have port out_bin, output, WIDTH bits: decoded binary value.
REQ-008 SHALL have port out_valid, output, 1 bit: output bundle valid.
REQ-009 SHALL have port out_ready, input, 1 bit: consumer takes the output bundle.
REQ-010 SHALL have ports step_up, step_down and step_err, outputs, 1 bit each: per-sample movement flags, qualified by out_valid.
REQ-011 SHALL have port err_sticky, output, 1 bit: a step error has occurred since the last clear.
REQ-012 SHALL have port err_clr, input, 1 bit: clears err_sticky and err_cnt.
REQ-013 SHALL have port err_cnt, output, 8 bits: saturating step-error count.

Function
REQ-014 SHALL decode as out_bin[WIDTH-1] = in_gray[WIDTH-1] and out_bin[i] = out_bin[i+1] XOR in_gray[i], for i from WIDTH-2 down to 0.
REQ-015 SHALL accept a sample on a rising edge where in_valid and in_ready are both 1.
REQ-016 SHALL drive in_ready = (not out_valid) or out_ready, combinationally.
REQ-017 SHALL register out_bin, the step flags and out_valid = 1 on the edge that accepts a sample, giving one-cycle latency.
REQ-018 SHALL hold the output bundle stable while out_valid = 1 and out_ready = 0.
REQ-019 SHALL clear out_valid on a drain edge (out_valid and out_ready both 1) with no accept.
REQ-020 SHALL load new data on an edge with both a drain and an accept, keeping out_valid = 1 with no bubble.
REQ-021 SHALL implement two states: INIT, where no previous value exists, and TRACK.
REQ-022 SHALL, on an accept in INIT, clear all step flags, store the decoded value as prev, and move to TRACK.
REQ-023 SHALL, on an accept in TRACK, compute delta = (new - prev) mod 2^WIDTH and then update prev.
REQ-024 SHALL set the flags from delta: 0 gives all flags 0; 1 gives step_up; 2^WIDTH-1 gives step_down; any other value gives step_err.
REQ-025 SHALL treat wrap-around as a legal step: binary 2^WIDTH-1 to 0 is step_up, and 0 to 2^WIDTH-1 is step_down.
REQ-026 SHALL set err_sticky on the accept edge that produces step_err.
REQ-027 SHALL, when err_clr and a new step_err occur on the same edge, let the error win: err_sticky = 1.
REQ-028 SHALL update prev only on accepted samples; stalls SHALL NOT affect tracking.

Reset
REQ-029 SHALL, while rst = 1, force out_valid, out_bin, all step flags, err_sticky, err_cnt and prev to 0, and the state to INIT.
REQ-030 SHALL give in_ready = 1 in reset.
REQ-031 SHALL, after rst is asserted mid-stream, discard any pending output and treat the next accepted sample as a first sample.

Configuration
REQ-032 SHALL, with macro GRAY_ERRCNT_EN defined, increment err_cnt on each step_err accept, saturating at 255.
REQ-033 SHALL, with GRAY_ERRCNT_EN defined, have err_clr zero err_cnt; if a step_err occurs on the same edge, err_cnt becomes 1.
REQ-034 SHALL, without GRAY_ERRCNT_EN, keep the err_cnt port and tie it to 0, with no counter logic; all other behaviour is identical.

Verification (WIDTH=4, out_ready=1 unless stated)
REQ-035 SHALL cover: reset, then accept gray 0000 -> next cycle out_valid=1, out_bin=0000, all step flags 0.
REQ-036 SHALL cover: gray 0000, 0001, 0011, 0010 on consecutive cycles -> out_bin 0,1,2,3, with step_up=1 on the last three.
REQ-037 SHALL cover: gray 1000 (binary 15), then 0000 -> step_up=1 (wrap); then 1000 -> step_down=1.
REQ-038 SHALL cover: gray 0001, then 0010 (binary 1 to 3) -> step_err=1 and err_sticky=1; err_cnt=1 with the macro, 0 without; err_clr on the next cycle -> both cleared.
REQ-039 SHALL cover: in_valid held at 1 with out_ready=0 for 3 cycles -> in_ready=0 and output held; then out_ready=1 -> the next sample loads on the same edge with no bubble.
REQ-040 SHALL cover: rst pulsed while out_valid=1 -> all outputs 0 and the state INIT; the next sample, gray 0110, gives out_bin=0100 with all step flags 0.
